seg_scan_mux: RTL and testbench

Time-multiplexed scan driver for a multi-digit common-anode 7-segment display. Holds a multi-digit BCD value, presents one digit per scan slot as a 4-bit BCD nibble to the downstream BCD-to-7-segment converter, and drives the matching active-low digit enable. New values enter through a staging register and reach the display only on frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg_scan_mux.sv | 140 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            BCD,
    output logic [DIGITS-1:0]     AN,
    output logic                  DP,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE_GUARD = 1'b0,
        DRIVE      = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  started_q;
    logic [4*DIGITS-1:0]   stage_q, stage_d;
    logic [DIGITS-1:0]     stage_dp_q, stage_dp_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic                  pending_q, pending_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  dp_q, dp_d;

    logic                  cnt_last;
    logic                  idx_last;
    logic                  boundary;
    logic [3:0]            disp_digit [DIGITS];
    logic [DIGITS-1:0]     blank;

    assign cnt_last = (cnt_q == CW'(PRESCALE - 1));
    assign idx_last = (idx_q == IW'(DIGITS - 1));
    assign cnt_d    = cnt_last ? '0 : cnt_q + CW'(1);
    assign idx_d    = cnt_last ? (idx_last ? '0 : idx_q + IW'(1)) : idx_q;

    // Outputs lag the counters by one edge, so the frame boundary is the edge
    // on which the registered outputs enter slot 0 (skipped right after reset).
    assign boundary = started_q && (cnt_q == '0) && (idx_q == '0);

    assign stage_d    = load ? digits_in : stage_q;
    assign stage_dp_d = load ? dp_in : stage_dp_q;
    assign disp_d     = (boundary && pending_q) ? stage_q : disp_q;
    assign disp_dp_d  = (boundary && pending_q) ? stage_dp_q : disp_dp_q;
    assign pending_d  = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
    assign frame_tick_d = boundary;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign disp_digit[gi] = disp_d[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS:0] zero_above;
    assign zero_above[DIGITS] = 1'b1;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            assign zero_above[gi] = zero_above[gi+1] && (disp_digit[gi] == 4'h0);
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = zero_above[gi];
            end
        end
    endgenerate
`else
    assign blank = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_GUARD: if (cnt_q != '0) state_d = DRIVE;
            DRIVE:      if (cnt_q == '0) state_d = IDLE_GUARD;
        endcase

        an_d = '1;
        if ((state_d == DRIVE) && !blank[idx_q]) begin
            an_d[idx_q] = 1'b0;
        end
        bcd_d = disp_digit[idx_q];
        dp_d  = disp_dp_d[idx_q] & ~blank[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE_GUARD;
            cnt_q        <= '0;
            idx_q        <= '0;
            started_q    <= 1'b0;
            stage_q      <= '0;
            stage_dp_q   <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            bcd_q        <= 4'h0;
            an_q         <= '1;
            dp_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            started_q    <= 1'b1;
            stage_q      <= stage_d;
            stage_dp_q   <= stage_dp_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign BCD        = bcd_q;
    assign AN         = an_q;
    assign DP         = dp_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4, PRESCALE=4 (16-cycle frames).
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  BCD;
    logic [3:0]  AN;
    logic        DP;
    logic        frame_tick;
    logic        pending;

    int tests_run = 0;
    int tests_failed = 0;

    seg_scan_mux #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .BCD        (BCD),
        .AN         (AN),
        .DP         (DP),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected AN n edges after reset release (slot cycle 0 is the guard).
    function automatic logic [3:0] an_after_release(input int n);
        int c;
        int s;
        logic [3:0] m;
        c = (n - 1) % 4;
        s = ((n - 1) / 4) % 4;
        m = 4'b0001 << s;
        return (c == 0) ? 4'b1111 : ~m;
    endfunction

    task automatic wait_frame();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (frame_tick === 1'b1) seen = 1;
        end
        if (!seen) check("frame_timeout", 32'd0, 32'd1);
    endtask

    // Entered on the first slot-0 sample of a frame; leaves on the next one.
    task automatic expect_frame(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] en);
        logic [3:0] m;
        for (int s = 0; s < 4; s++) begin
            m = 4'b0001 << s;
            for (int c = 0; c < 4; c++) begin
                check($sformatf("bcd_s%0d_c%0d_%h", s, c, val), {28'd0, BCD}, {28'd0, val[4*s +: 4]});
                check($sformatf("dp_s%0d_c%0d_%h", s, c, val), {31'd0, DP}, {31'd0, dp[s] & en[s]});
                check($sformatf("an_s%0d_c%0d_%h", s, c, val), {28'd0, AN},
                      {28'd0, ((c == 0) || !en[s]) ? 4'b1111 : ~m});
                check($sformatf("ftick_s%0d_c%0d", s, c), {31'd0, frame_tick},
                      {31'd0, (s == 0 && c == 0)});
                tick();
            end
        end
        $display("[TB] frame %h dp=%b en=%b checked", val, dp, en);
    endtask

    task automatic load_value(input logic [15:0] val, input logic [3:0] dp);
        load = 1'b1;
        digits_in = val;
        dp_in = dp;
        tick();
        load = 1'b0;
        $display("[TB] load %h dp=%b", val, dp);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        digits_in = '0;
        dp_in = '0;

        repeat (3) tick();
        check("rst_an", {28'd0, AN}, 32'hF);
        check("rst_bcd", {28'd0, BCD}, 32'h0);
        check("rst_dp", {31'd0, DP}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_ftick", {31'd0, frame_tick}, 32'd0);
        $display("[TB] reset state checked");

        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check($sformatf("rel_an_%0d", n), {28'd0, AN}, {28'd0, an_after_release(n)});
            check($sformatf("rel_ftick_%0d", n), {31'd0, frame_tick}, {31'd0, (n == 17)});
            check($sformatf("rel_bcd_%0d", n), {28'd0, BCD}, 32'h0);
        end
        $display("[TB] post-release scan checked");

        // Load/commit mid-frame.
        load_value(16'h1234, 4'b0100);
        check("lc_pending_set", {31'd0, pending}, 32'd1);
        wait_frame();
        check("lc_pending_clr", {31'd0, pending}, 32'd0);
        check("lc_first_bcd", {28'd0, BCD}, 32'h4);
        expect_frame(16'h1234, 4'b0100, 4'b1111);

        // Double write inside one frame: last write wins.
        load_value(16'h1111, 4'b0000);
        load_value(16'h2222, 4'b0000);
        check("dw_pending", {31'd0, pending}, 32'd1);
        wait_frame();
        check("dw_pending_clr", {31'd0, pending}, 32'd0);
        expect_frame(16'h2222, 4'b0000, 4'b1111);

        // Boundary collision: 5678 loaded on the boundary edge with 1234 pending.
        repeat (2) tick();
        load_value(16'h1234, 4'b0000);
        repeat (12) tick();
        check("bc_pending_pre", {31'd0, pending}, 32'd1);
        load_value(16'h5678, 4'b0000);
        check("bc_ftick", {31'd0, frame_tick}, 32'd1);
        check("bc_pending_stays", {31'd0, pending}, 32'd1);
        expect_frame(16'h1234, 4'b0000, 4'b1111);
        check("bc_pending_clr", {31'd0, pending}, 32'd0);
        expect_frame(16'h5678, 4'b0000, 4'b1111);

        // Mid-frame asynchronous reset discards staged data.
        repeat (5) tick();
        load_value(16'h9999, 4'b1111);
        repeat (3) tick();
        check("mr_pre_an", {28'd0, AN}, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check("mr_an", {28'd0, AN}, 32'hF);
        check("mr_bcd", {28'd0, BCD}, 32'h0);
        check("mr_dp", {31'd0, DP}, 32'd0);
        check("mr_pending", {31'd0, pending}, 32'd0);
        check("mr_ftick", {31'd0, frame_tick}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            check($sformatf("mr_rel_an_%0d", n), {28'd0, AN}, {28'd0, an_after_release(n)});
            check($sformatf("mr_rel_bcd_%0d", n), {28'd0, BCD}, 32'h0);
            check($sformatf("mr_rel_ftick_%0d", n), {31'd0, frame_tick}, {31'd0, (n == 17)});
        end
        check("mr_rel_pending", {31'd0, pending}, 32'd0);
        $display("[TB] mid-frame reset checked");

        // Leading-zero handling.
        load_value(16'h0045, 4'b1111);
        wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
        expect_frame(16'h0045, 4'b1111, 4'b0011);
`else
        expect_frame(16'h0045, 4'b1111, 4'b1111);
`endif
        load_value(16'h0000, 4'b1111);
        wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
        expect_frame(16'h0000, 4'b1111, 4'b0001);
`else
        expect_frame(16'h0000, 4'b1111, 4'b1111);
`endif
        load_value(16'h0405, 4'b1111);
        wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
        expect_frame(16'h0405, 4'b1111, 4'b0111);
`else
        expect_frame(16'h0405, 4'b1111, 4'b1111);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
